// File: rtl/pattern_pkg.sv
// Shared types and helpers for the HEX phase rotation sequencer.
// Phase constants, FSM state encoding and the phase advance rule.
package pattern_pkg;

  localparam logic [1:0] PH_A = 2'b00;
  localparam logic [1:0] PH_B = 2'b01;
  localparam logic [1:0] PH_C = 2'b10;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // One phase step; dir=0 forward, dir=1 reverse; 11 recovers to 00
  function automatic logic [1:0] next_phase(
    input logic [1:0] cur,
    input logic       dir
  );
    logic [1:0] nxt;
    nxt = PH_A;
    case (cur)
      PH_A:    nxt = dir ? PH_C : PH_B;
      PH_B:    nxt = dir ? PH_A : PH_C;
      PH_C:    nxt = dir ? PH_B : PH_A;
      default: nxt = PH_A;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pattern_rotate_ctrl_rate_divider.sv
// Prescaler producing a one-cycle pulse every TICK_DIV enabled cycles.
// Held at zero whenever disabled or cleared.
module rate_divider #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic Enable,
  input  logic Clear,
  output logic Pulse
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_term;

  // Next count: wrap at terminal, zero when idle or cleared
  always_comb begin
    at_term = (cnt_q == TERM);
    Pulse   = Enable & ~Clear & at_term;
    cnt_d   = cnt_q + CNT_W'(1);
    if (Clear || !Enable || at_term) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pattern_rotate_ctrl.sv
// Phase sequencer for the 3-phase HEX rotation muxes.
// Auto-rotate, single-step button, direction and direct load.
module pattern_rotate_ctrl
  import pattern_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Dir,
  input  logic       Step_n,
  input  logic       Load,
  input  logic [1:0] Load_sel,
  output logic [1:0] Sel,
  output logic       Tick,
  output logic       Running
);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic       tick_q, tick_d;
  logic       sync1_q, sync2_q, prev_q;
  logic       press, pulse, load_ok, adv;

  assign load_ok = Load && (Load_sel != 2'b11);
  assign press   = prev_q & ~sync2_q;

  rate_divider #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_div (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .Enable   (state_q == ST_RUN),
    .Clear    (load_ok),
    .Pulse    (pulse)
  );

  // Button synchroniser and previous-value flop, idle high
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= Step_n;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Next state, load/advance priority and tick
  always_comb begin
    state_d = Run ? ST_RUN : ST_HOLD;
    sel_d   = sel_q;
    adv     = 1'b0;
    if (load_ok) begin
      sel_d = Load_sel;
    end else begin
      unique case (state_q)
        ST_HOLD: adv = press;
        ST_RUN:  adv = pulse;
      endcase
      if (adv) begin
        sel_d = next_phase(sel_q, Dir);
      end
    end
    tick_d = adv;
  end

  // State, phase and tick registers
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_HOLD;
      sel_q   <= PH_A;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tick_q  <= tick_d;
    end
  end

  assign Sel     = sel_q;
  assign Tick    = tick_q;
  assign Running = (state_q == ST_RUN);

endmodule
